// File: rtl/rx_comma_align_sipo.sv
// Serial-to-parallel receive deserializer with comma hunt, word alignment and lock qualification.
// Optional realign event counter output is enabled by defining SIPO_REALIGN_CNT_EN.
module rx_comma_align_sipo #(
  parameter int                 WORD_W     = 10,
  parameter int                 COMMA_W    = 7,
  parameter logic [COMMA_W-1:0] COMMA_P    = 7'b1111100,
  parameter int                 LOCK_CNT   = 3,
  parameter int                 UNLOCK_CNT = 4
) (
  input  logic              BitCLK,
  input  logic              Reset,
  input  logic              Serial,
  input  logic              AlignEn,
  output logic [WORD_W-1:0] RxParallel,
  output logic              RxValid,
  output logic              CommaDet,
  output logic              Locked
`ifdef SIPO_REALIGN_CNT_EN
  ,
  output logic [7:0]        RealignCnt
`endif
);

  localparam int                BCW       = $clog2(WORD_W);
  localparam logic [BCW-1:0]    BC_LAST   = BCW'(WORD_W - 1);
  localparam logic [3:0]        LOCK_TH   = 4'(LOCK_CNT);
  localparam logic [3:0]        UNLOCK_TH = 4'(UNLOCK_CNT);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t            state, state_next;
  logic [WORD_W-1:0] shift_reg;
  logic [BCW-1:0]    bit_cnt, bit_cnt_next;
  logic [3:0]        good_cnt, good_cnt_next;
  logic [3:0]        bad_cnt, bad_cnt_next;
  logic              comma, boundary, capture, realign;

  // Both running-disparity polarities of the comma are accepted.
  assign comma    = (shift_reg[COMMA_W-1:0] == COMMA_P) ||
                    (shift_reg[COMMA_W-1:0] == ~COMMA_P);
  assign boundary = (bit_cnt == BC_LAST);

  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    bad_cnt_next  = bad_cnt;
    capture       = 1'b0;
    realign       = 1'b0;

    unique case (state)
      HUNT: begin
        if (comma && AlignEn) realign = 1'b1;
      end
      CHECK: begin
        // An on-boundary comma always counts toward lock and never realigns.
        if (boundary) begin
          capture = 1'b1;
          if (comma && AlignEn && (good_cnt < LOCK_TH)) begin
            good_cnt_next = good_cnt + 4'd1;
            if (good_cnt + 4'd1 == LOCK_TH) state_next = LOCKED;
          end
        end else if (comma && AlignEn) begin
          realign = 1'b1;
        end
      end
      LOCKED: begin
        if (boundary) begin
          capture = 1'b1;
          if (comma && AlignEn) bad_cnt_next = 4'd0;
        end else if (comma && AlignEn && (bad_cnt < UNLOCK_TH)) begin
          if (bad_cnt + 4'd1 == UNLOCK_TH) begin
            state_next    = HUNT;
            bad_cnt_next  = 4'd0;
            good_cnt_next = 4'd0;
          end else begin
            bad_cnt_next = bad_cnt + 4'd1;
          end
        end
      end
      default: state_next = HUNT;
    endcase

    if (realign) begin
      capture       = 1'b1;
      good_cnt_next = 4'd1;
      state_next    = (LOCK_CNT == 1) ? LOCKED : CHECK;
    end

    bit_cnt_next = (realign || boundary) ? '0 : bit_cnt + BCW'(1);
  end

  always_ff @(posedge BitCLK or negedge Reset) begin
    if (!Reset) begin
      state      <= HUNT;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      good_cnt   <= 4'd0;
      bad_cnt    <= 4'd0;
      RxParallel <= '0;
      RxValid    <= 1'b0;
      CommaDet   <= 1'b0;
      Locked     <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= {Serial, shift_reg[WORD_W-1:1]};
      bit_cnt   <= bit_cnt_next;
      good_cnt  <= good_cnt_next;
      bad_cnt   <= bad_cnt_next;
      RxValid   <= capture;
      CommaDet  <= capture && comma;
      if (capture) RxParallel <= shift_reg;
      Locked    <= (state_next == LOCKED);
    end
  end

`ifdef SIPO_REALIGN_CNT_EN
  always_ff @(posedge BitCLK or negedge Reset) begin
    if (!Reset) begin
      RealignCnt <= 8'd0;
    end else if (!AlignEn) begin
      RealignCnt <= 8'd0;
    end else if (realign && (RealignCnt != 8'hFF)) begin
      RealignCnt <= RealignCnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_comma_align_sipo.sv
// Randomized bench for rx_comma_align_sipo against a bit-history / boundary-phase reference model.
// Every cycle the registered outputs are compared with the model's expectation.
module tb_rx_comma_align_sipo;
  localparam int         W       = 10;
  localparam logic [6:0] P       = 7'b1111100;
  localparam int         LOCKN   = 3;
  localparam int         UNLOCKN = 4;

  logic         BitCLK = 1'b0;
  logic         Reset;
  logic         Serial;
  logic         AlignEn;
  logic [W-1:0] RxParallel;
  logic         RxValid, CommaDet, Locked;
`ifdef SIPO_REALIGN_CNT_EN
  logic [7:0]   RealignCnt;
`endif

  rx_comma_align_sipo dut (
    .BitCLK     (BitCLK),
    .Reset      (Reset),
    .Serial     (Serial),
    .AlignEn    (AlignEn),
    .RxParallel (RxParallel),
    .RxValid    (RxValid),
    .CommaDet   (CommaDet),
    .Locked     (Locked)
`ifdef SIPO_REALIGN_CNT_EN
    ,
    .RealignCnt (RealignCnt)
`endif
  );

  always #5 BitCLK = ~BitCLK;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: state 0=hunt 1=check 2=locked; boundary phase from the last anchor cycle.
  int           m_st, m_good, m_bad, m_anchor, m_n, m_rcnt;
  bit           m_hist[$];
  logic [W-1:0] m_par;
  bit           m_valid, m_cd;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_st = 0; m_good = 0; m_bad = 0; m_anchor = 0; m_n = 0; m_rcnt = 0;
    m_hist.delete();
    m_par = '0; m_valid = 0; m_cd = 0;
  endfunction

  function automatic void model_step(bit s, bit en);
    logic [W-1:0] sr;
    bit comma, bnd, realign;
    // The window holds the last W received bits, oldest at bit 0.
    for (int i = 0; i < W; i++) begin
      int idx;
      idx   = m_hist.size() - W + i;
      sr[i] = (idx >= 0) ? m_hist[idx] : 1'b0;
    end
    comma   = (sr[6:0] == P) || (sr[6:0] == ~P);
    bnd     = ((m_n - m_anchor) % W) == (W - 1);
    m_valid = 0; m_cd = 0; realign = 0;
    if (m_st == 0) begin
      realign = comma && en;
    end else if (bnd) begin
      m_valid = 1; m_par = sr; m_cd = comma;
      if (comma && en) begin
        if (m_st == 1) begin
          if (m_good < LOCKN) m_good++;
          if (m_good == LOCKN) m_st = 2;
        end else begin
          m_bad = 0;
        end
      end
    end else if (comma && en) begin
      if (m_st == 1) realign = 1;
      else begin
        if (m_bad < UNLOCKN) m_bad++;
        if (m_bad == UNLOCKN) begin m_st = 0; m_bad = 0; m_good = 0; end
      end
    end
    if (realign) begin
      m_valid = 1; m_par = sr; m_cd = 1;
      m_anchor = m_n + 1; m_good = 1;
      m_st = (LOCKN == 1) ? 2 : 1;
      if (m_rcnt < 255) m_rcnt++;
    end
    if (!en) m_rcnt = 0;
    m_hist.push_back(s);
    if (m_hist.size() > W) void'(m_hist.pop_front());
    m_n++;
  endfunction

  task automatic check_outputs(string tag);
    check(tag, {19'd0, Locked, CommaDet, RxValid, RxParallel},
               {19'd0, (m_st == 2), m_cd, m_valid, m_par});
`ifdef SIPO_REALIGN_CNT_EN
    check({tag, "_rcnt"}, {24'd0, RealignCnt}, 32'(m_rcnt));
`endif
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(bit s, bit en);
    Serial  = s;
    AlignEn = en;
    model_step(s, en);
    @(posedge BitCLK);
    @(negedge BitCLK);
    check_outputs("cycle");
  endtask

  task automatic send_word(logic [W-1:0] w, bit en);
    for (int i = 0; i < W; i++) step(w[i], en);
    $display("word %h en %0b -> valid %0b comma %0b par %h locked %0b",
             w, en, RxValid, CommaDet, RxParallel, Locked);
  endtask

  // Asserted between clock edges so only an asynchronous reset clears the outputs in time.
  task automatic apply_reset();
    #1 Reset = 1'b0;
    model_reset();
    #1 check_outputs("reset_async");
    repeat (2) begin
      @(negedge BitCLK);
      check_outputs("reset_hold");
    end
    Reset = 1'b1;
  endtask

  initial begin
    int r;
    bit en;
    Reset = 1'b1; Serial = 1'b0; AlignEn = 1'b1;
    @(negedge BitCLK);
    apply_reset();

    // Junk bits, then three aligned K28.5 RD- to lock, then data and another comma.
    step(0, 1); step(1, 1); step(0, 1);
    repeat (3) send_word(10'h17C, 1);
    send_word(10'h2AA, 1);
    send_word(10'h17C, 1);
    send_word(10'h2AA, 1);

    // Mid-stream reset, two commas into CHECK, then a 1-bit slipped RD+ comma.
    step(1, 1);
    apply_reset();
    repeat (2) send_word(10'h17C, 1);
    step(0, 1);
    repeat (3) send_word(10'h283, 1);
    send_word(10'h2AA, 1);

    // Four off-boundary commas drop lock; then relock.
    step(0, 1);
    repeat (4) send_word(10'h17C, 1);
    repeat (3) send_word(10'h17C, 1);
    send_word(10'h2AA, 1);

    // Three off-boundary commas, then back on the boundary: lock must hold.
    step(0, 1);
    repeat (3) send_word(10'h17C, 1);
    repeat (9) step(0, 1);
    send_word(10'h17C, 1);
    send_word(10'h2AA, 1);

    // AlignEn low in HUNT keeps the aligner idle; re-enabling realigns on the next comma.
    apply_reset();
    repeat (4) send_word(10'h17C, 0);
    send_word(10'h17C, 1);
    send_word(10'h2AA, 1);

    // Randomized mix of commas, data, bit slips, AlignEn drops and resets.
    repeat (400) begin
      r  = $urandom_range(0, 19);
      en = ($urandom_range(0, 15) != 0);
      if (r < 6)       send_word(10'h17C, en);
      else if (r < 10) send_word(10'h283, en);
      else if (r < 12) step(1'($urandom), en);
      else if (r == 12 && $urandom_range(0, 3) == 0) apply_reset();
      else             send_word(W'($urandom), en);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard bound on run time in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rx_comma_align_sipo.md
Name: rx_comma_align_sipo

Overview:
- Parametrised serial-to-parallel deserializer for the receive path, one bit per BitCLK cycle.
- Hunts for comma patterns (either running-disparity polarity) and aligns word boundaries to them.
- Qualifies alignment with a lock/unlock state machine and presents aligned words with a valid strobe to the downstream decoder.

Parameters:
- WORD_W, 10, parallel word width in bits (>= COMMA_W + 1).
- COMMA_W, 7, number of comma bits compared, located at shift_reg[COMMA_W-1:0].
- COMMA_P, 7'b1111100, comma pattern; its bitwise complement is also a comma.
- LOCK_CNT, 3, consecutive on-boundary commas required to declare lock (1..15).
- UNLOCK_CNT, 4, off-boundary commas in LOCKED, without an intervening on-boundary comma, that force loss of lock (1..15).

Ports:
- BitCLK  input  1  bit clock
- Reset  input  1  asynchronous, active-low reset
- Serial  input  1  serial data, first-transmitted bit first
- AlignEn  input  1  1 = realignment permitted; 0 = boundary frozen
- RxParallel  output  WORD_W  aligned word; first-received bit at LSB
- RxValid  output  1  one-cycle pulse when RxParallel is updated
- CommaDet  output  1  one-cycle pulse together with RxValid when the captured word is a comma
- Locked  output  1  high while the state is LOCKED

Behaviour:
- Reset (async, Reset=0): shift_reg=0, bit_cnt=0, good_cnt=0, bad_cnt=0, state=HUNT, RxParallel=0, RxValid=0, CommaDet=0, Locked=0.
- Shift: every cycle, shift_reg <= {Serial, shift_reg[WORD_W-1:1]}.
- comma (combinational on the registered shift_reg): shift_reg[COMMA_W-1:0] == COMMA_P, or == ~COMMA_P.
- bit_cnt counts 0..WORD_W-1 and wraps to 0. A cycle is a boundary when bit_cnt == WORD_W-1.
- Capture: RxParallel <= shift_reg; RxValid=1 and CommaDet=comma, both registered, so visible on the next cycle.
- Realign: capture the current shift_reg; bit_cnt <= 0, so the next boundary falls exactly WORD_W cycles later.
- HUNT:
  - No capture on boundaries.
  - comma and AlignEn: realign; good_cnt <= 1; go to CHECK, or directly to LOCKED if LOCK_CNT == 1.
- CHECK:
  - Capture on every boundary.
  - Boundary with comma: good_cnt+1; go to LOCKED when this reaches LOCK_CNT.
  - Non-boundary comma with AlignEn: realign, good_cnt <= 1, stay in CHECK.
  - Boundary without comma: no change.
- LOCKED:
  - Capture on every boundary.
  - Boundary with comma: bad_cnt <= 0.
  - Non-boundary comma: bad_cnt+1. On reaching UNLOCK_CNT, go to HUNT with bad_cnt=0 and good_cnt=0.
  - No realignment while LOCKED.
- Leaving LOCKED: Locked drops the cycle after the transition to HUNT. No capture in the HUNT cycle that follows.
- AlignEn=0:
  - State, good_cnt and bad_cnt are frozen; bit_cnt keeps counting.
  - Captures continue in CHECK/LOCKED.
  - HUNT does not exit.
- Simultaneous events: a comma on a boundary is treated as on-boundary, never as a realign.
- Counters saturate at their thresholds and never wrap.
- Latency: RxParallel/RxValid appear one cycle after the last bit of the word sits in shift_reg.
- Reset mid-word: everything returns to its reset value immediately; any partial word is discarded.

Optional Feature:
- Macro: SIPO_REALIGN_CNT_EN.
- When defined:
  - Adds output RealignCnt [7:0], reset to 0.
  - Increments on every realign event (HUNT exit or CHECK realign) and saturates at 255.
  - Cleared whenever AlignEn is 0.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-stream with Reset=0 for 2 cycles -> all outputs 0 during reset, state HUNT; no RxValid until a comma is seen.
- 3 junk bits, then K28.5 RD- (shift_reg=10'h17C) three times at a 10-bit pitch -> RxValid+CommaDet with RxParallel=10'h17C after each comma; Locked=1 the cycle after the third.
- Locked, then data word 10'h2AA on a boundary -> RxValid=1, CommaDet=0, RxParallel=10'h2AA, Locked stays 1.
- In CHECK (good_cnt=2), a K28.5 RD+ (10'h283) slipped by 1 bit -> realign; boundary moves; good_cnt=1; Locked stays 0.
- Locked, then 4 off-boundary commas with no on-boundary comma -> Locked falls after the 4th. With only 3, then an aligned comma -> Locked stays 1 and bad_cnt returns to 0.
- AlignEn=0 in HUNT with repeated commas -> no RxValid, Locked=0. With SIPO_REALIGN_CNT_EN: RealignCnt=0; after AlignEn=1 and one comma -> RealignCnt=1.
